// File: rtl/axi_lite_pkg.sv
// Shared definitions for the MEM-stage AXI4-Lite controller: response codes,
// controller state and the load/store access-type encodings.
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      StIdle,
      StWr,
      StWrResp,
      StRdAddr,
      StRdData,
      StDone
   } state_t;

   localparam logic [1:0] STORE_SB = 2'b00;
   localparam logic [1:0] STORE_SH = 2'b01;
   localparam logic [1:0] STORE_SW = 2'b10;

   localparam logic [2:0] LOAD_LB  = 3'b000;
   localparam logic [2:0] LOAD_LH  = 3'b001;
   localparam logic [2:0] LOAD_LW  = 3'b010;
   localparam logic [2:0] LOAD_LBU = 3'b100;
   localparam logic [2:0] LOAD_LHU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store replication and strobes, load
// extraction with sign/zero extension, and misalignment detection.
module lsu_align
   import axi_lite_pkg::*;
(
   input  logic [1:0]  req_off,
   input  logic [1:0]  store_type,
   input  logic [2:0]  load_type,
   input  logic [31:0] wdata,
   input  logic [1:0]  ld_off,
   input  logic [2:0]  ld_type,
   input  logic [31:0] rdata,
   output logic [31:0] st_data,
   output logic [3:0]  st_strb,
   output logic        st_misaligned,
   output logic        ld_misaligned,
   output logic [31:0] ld_data
);

   logic [31:0] shifted;

   always_comb begin
      st_data       = wdata;
      st_strb       = 4'b1111;
      st_misaligned = 1'b0;
      case (store_type)
         STORE_SB: begin
            st_data = {4{wdata[7:0]}};
            st_strb = 4'b0001 << req_off;
         end
         STORE_SH: begin
            st_data       = {2{wdata[15:0]}};
            st_strb       = 4'b0011 << {req_off[1], 1'b0};
            st_misaligned = req_off[0];
         end
         default: st_misaligned = (req_off != 2'b00);
      endcase
   end

   always_comb begin
      case (load_type)
         LOAD_LB, LOAD_LBU: ld_misaligned = 1'b0;
         LOAD_LH, LOAD_LHU: ld_misaligned = req_off[0];
         default:           ld_misaligned = (req_off != 2'b00);
      endcase
   end

   // Move the addressed lane down to bit 0 before extending.
   assign shifted = rdata >> {ld_off, 3'b000};

   always_comb begin
      case (ld_type)
         LOAD_LB:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
         LOAD_LBU: ld_data = {24'b0, shifted[7:0]};
         LOAD_LH:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
         LOAD_LHU: ld_data = {16'b0, shifted[15:0]};
         default:  ld_data = shifted;
      endcase
   end

endmodule

// File: rtl/mem_axi_ctrl.sv
// MEM-stage load/store controller: turns one pipeline request into a single
// AXI4-Lite read or write, stalling the pipeline until the one-cycle DONE.
module mem_axi_ctrl
   import axi_lite_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [31:0]           addr,
   input  logic [31:0]           wdata,
   input  logic [1:0]            store_type,
   input  logic [2:0]            load_type,
   output logic                  stall,
   output logic [31:0]           read_data,
   output logic                  done,
   output logic                  err,
   output logic [ADDR_WIDTH-1:0] awaddr,
   output logic [2:0]            awprot,
   output logic                  awvalid,
   input  logic                  awready,
   output logic [31:0]           wdata_o,
   output logic [3:0]            wstrb,
   output logic                  wvalid,
   input  logic                  wready,
   input  logic [1:0]            bresp,
   input  logic                  bvalid,
   output logic                  bready,
   output logic [ADDR_WIDTH-1:0] araddr,
   output logic [2:0]            arprot,
   output logic                  arvalid,
   input  logic                  arready,
   input  logic [31:0]           rdata,
   input  logic [1:0]            rresp,
   input  logic                  rvalid,
   output logic                  rready
);

   state_t      state_q;
   logic [1:0]  ld_off_q;
   logic [2:0]  ld_type_q;
   logic [31:0] word_addr;
   logic [31:0] st_data;
   logic [3:0]  st_strb;
   logic        st_misaligned;
   logic        ld_misaligned;
   logic [31:0] ld_data;

   lsu_align u_lsu_align (
      .req_off       (addr[1:0]),
      .store_type    (store_type),
      .load_type     (load_type),
      .wdata         (wdata),
      .ld_off        (ld_off_q),
      .ld_type       (ld_type_q),
      .rdata         (rdata),
      .st_data       (st_data),
      .st_strb       (st_strb),
      .st_misaligned (st_misaligned),
      .ld_misaligned (ld_misaligned),
      .ld_data       (ld_data)
   );

   assign word_addr = {addr[31:2], 2'b00};
   assign awprot    = 3'b000;
   assign arprot    = 3'b000;
   assign stall     = ((state_q == StIdle) && (mem_read || mem_write)) ||
                      ((state_q != StIdle) && (state_q != StDone));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         ld_off_q  <= 2'b00;
         ld_type_q <= 3'b000;
         awaddr    <= '0;
         awvalid   <= 1'b0;
         wdata_o   <= '0;
         wstrb     <= '0;
         wvalid    <= 1'b0;
         bready    <= 1'b0;
         araddr    <= '0;
         arvalid   <= 1'b0;
         rready    <= 1'b0;
         read_data <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (mem_write) begin
                  if (st_misaligned) begin
                     state_q   <= StDone;
                     done      <= 1'b1;
                     err       <= 1'b1;
                     read_data <= '0;
                  end else begin
                     state_q <= StWr;
                     awaddr  <= ADDR_WIDTH'(word_addr);
                     wdata_o <= st_data;
                     wstrb   <= st_strb;
                     awvalid <= 1'b1;
                     wvalid  <= 1'b1;
                  end
               end else if (mem_read) begin
                  ld_off_q  <= addr[1:0];
                  ld_type_q <= load_type;
                  if (ld_misaligned) begin
                     state_q   <= StDone;
                     done      <= 1'b1;
                     err       <= 1'b1;
                     read_data <= '0;
                  end else begin
                     state_q <= StRdAddr;
                     araddr  <= ADDR_WIDTH'(word_addr);
                     arvalid <= 1'b1;
                  end
               end
            end
            StWr: begin
               // A dropped valid means that channel has already handshaken.
               if (awready) awvalid <= 1'b0;
               if (wready)  wvalid  <= 1'b0;
               if ((!awvalid || awready) && (!wvalid || wready)) begin
                  state_q <= StWrResp;
                  bready  <= 1'b1;
               end
            end
            StWrResp: begin
               if (bvalid) begin
                  state_q <= StDone;
                  bready  <= 1'b0;
                  done    <= 1'b1;
                  err     <= (bresp != RESP_OKAY);
               end
            end
            StRdAddr: begin
               if (arready) begin
                  state_q <= StRdData;
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
               end
            end
            StRdData: begin
               if (rvalid) begin
                  state_q   <= StDone;
                  rready    <= 1'b0;
                  done      <= 1'b1;
                  read_data <= ld_data;
                  err       <= (rresp != RESP_OKAY);
               end
            end
            StDone: begin
               state_q <= StIdle;
               done    <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_axi_ctrl.sv
// Self-checking bench for mem_axi_ctrl: a configurable AXI4-Lite slave plus an
// arithmetic reference model, driven by directed and randomized requests.
module tb_mem_axi_ctrl;
   import axi_lite_pkg::*;

   logic        clk;
   logic        rst;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [1:0]  store_type;
   logic [2:0]  load_type;
   logic        stall;
   logic [31:0] read_data;
   logic        done;
   logic        err;
   logic [31:0] awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata_o;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [31:0] araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   int          n_vectors;
   int          n_miscompares;
   logic [31:0] model_rd;

   int          cfg_aw_delay;
   int          cfg_w_delay;
   int          cfg_ar_delay;
   int          cfg_r_delay;
   logic [1:0]  cfg_resp;
   logic [31:0] cfg_rdata;

   mem_axi_ctrl #(.ADDR_WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .addr       (addr),
      .wdata      (wdata),
      .store_type (store_type),
      .load_type  (load_type),
      .stall      (stall),
      .read_data  (read_data),
      .done       (done),
      .err        (err),
      .awaddr     (awaddr),
      .awprot     (awprot),
      .awvalid    (awvalid),
      .awready    (awready),
      .wdata_o    (wdata_o),
      .wstrb      (wstrb),
      .wvalid     (wvalid),
      .wready     (wready),
      .bresp      (bresp),
      .bvalid     (bvalid),
      .bready     (bready),
      .araddr     (araddr),
      .arprot     (arprot),
      .arvalid    (arvalid),
      .arready    (arready),
      .rdata      (rdata),
      .rresp      (rresp),
      .rvalid     (rvalid),
      .rready     (rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed no end of test, expected $finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vectors++;
      assert (obs === exp) else begin
         n_miscompares++;
         $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Slave: readies after a programmable wait, responses once both/the address handshake is seen.
   initial begin
      bit aw_hs, w_hs, ar_hs, b_hs, r_hs, aw_got, w_got, r_pend;
      int aw_cnt, w_cnt, ar_cnt, r_cnt;
      awready = 0; wready = 0; arready = 0; bvalid = 0; bresp = 0;
      rvalid = 0; rresp = 0; rdata = 0;
      aw_got = 0; w_got = 0; r_pend = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
      forever begin
         @(negedge clk);
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         ar_hs = arvalid && arready;
         b_hs  = bvalid && bready;
         r_hs  = rvalid && rready;
         @(posedge clk);
         #1;
         if (rst) begin
            awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
            aw_got = 0; w_got = 0; r_pend = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
         end else begin
            if (aw_hs) begin aw_got = 1; aw_cnt = 0; end
            if (w_hs) begin w_got = 1; w_cnt = 0; end
            if (b_hs) bvalid = 0;
            if (aw_got && w_got) begin
               bvalid = 1; bresp = cfg_resp; aw_got = 0; w_got = 0;
            end
            if (ar_hs) begin ar_cnt = 0; r_pend = 1; r_cnt = 0; end
            if (r_hs) rvalid = 0;
            if (r_pend) begin
               if (r_cnt >= cfg_r_delay) begin
                  rvalid = 1; rdata = cfg_rdata; rresp = cfg_resp; r_pend = 0;
               end else r_cnt++;
            end
            awready = awvalid && (aw_cnt >= cfg_aw_delay);
            if (awvalid && !awready) aw_cnt++;
            wready = wvalid && (w_cnt >= cfg_w_delay);
            if (wvalid && !wready) w_cnt++;
            arready = arvalid && (ar_cnt >= cfg_ar_delay);
            if (arvalid && !arready) ar_cnt++;
         end
      end
   end

   task automatic run_txn(input string tag, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [1:0] st, input logic [2:0] lt,
                          input int awd, input int wdd, input int ard, input int rdd,
                          input logic [1:0] resp, input logic [31:0] rdv);
      int size, off, v, exp_done, done_cyc, stall_cnt, aw_cyc, w_cyc, ar_cyc, overlap;
      bit mis;
      logic [31:0] exp_data, exp_rd, sh, got_wdata, got_awaddr, got_araddr, got_rd;
      logic [3:0]  exp_strb, got_wstrb;
      logic        got_err, got_stall;

      cfg_aw_delay = awd; cfg_w_delay = wdd; cfg_ar_delay = ard; cfg_r_delay = rdd;
      cfg_resp = resp; cfg_rdata = rdv;

      // Reference model: access size, alignment, lane data and expected latency.
      off = int'(a[1:0]);
      if (wr) size = (st == STORE_SB) ? 1 : (st == STORE_SH) ? 2 : 4;
      else    size = (lt[1:0] == 2'b00) ? 1 : (lt[1:0] == 2'b01) ? 2 : 4;
      mis = (off % size) != 0;
      if (size == 1) begin
         exp_data = (wd & 32'hFF) * 32'h0101_0101;
         exp_strb = 4'(1 << off);
      end else if (size == 2) begin
         exp_data = (wd & 32'hFFFF) * 32'h0001_0001;
         exp_strb = 4'(3 << off);
      end else begin
         exp_data = wd;
         exp_strb = 4'hF;
      end
      sh = rdv >> (8 * off);
      if (size == 1) begin
         v = int'(sh & 32'hFF);
         if (!lt[2] && v >= 128) v -= 256;
      end else if (size == 2) begin
         v = int'(sh & 32'hFFFF);
         if (!lt[2] && v >= 32768) v -= 65536;
      end else v = int'(sh);
      if (mis)     exp_rd = 32'h0;
      else if (wr) exp_rd = model_rd;
      else         exp_rd = 32'(v);
      if (mis)     exp_done = 1;
      else if (wr) exp_done = 3 + ((awd > wdd) ? awd : wdd);
      else         exp_done = 3 + ard + rdd;

      @(negedge clk);
      mem_write = wr; mem_read = !wr; addr = a; wdata = wd; store_type = st; load_type = lt;
      #1;
      check({tag, "/stall_c0"}, 32'(stall), 32'd1);
      stall_cnt = stall ? 1 : 0;
      aw_cyc = 0; w_cyc = 0; ar_cyc = 0; overlap = 0; done_cyc = -1;
      got_wdata = 'x; got_wstrb = 'x; got_awaddr = 'x; got_araddr = 'x;
      got_rd = 'x; got_err = 1'bx; got_stall = 1'bx;
      for (int k = 1; k <= 60 && done_cyc < 0; k++) begin
         @(negedge clk);
         if (awvalid) begin aw_cyc++; got_awaddr = awaddr; end
         if (wvalid) begin w_cyc++; got_wdata = wdata_o; got_wstrb = wstrb; end
         if (arvalid) begin ar_cyc++; got_araddr = araddr; end
         if (bready && (awvalid || wvalid)) overlap++;
         if (done) begin
            done_cyc = k; got_rd = read_data; got_err = err; got_stall = stall;
         end else if (stall) stall_cnt++;
      end
      check({tag, "/done_cycle"}, 32'(done_cyc), 32'(exp_done));
      check({tag, "/stall_cycles"}, 32'(stall_cnt), 32'(exp_done));
      check({tag, "/stall_in_done"}, 32'(got_stall), 32'd0);
      check({tag, "/err"}, 32'(got_err), 32'(mis || (resp != RESP_OKAY)));
      check({tag, "/read_data"}, got_rd, exp_rd);
      if (mis) begin
         check({tag, "/no_axi"}, 32'(aw_cyc + w_cyc + ar_cyc), 32'd0);
      end else if (wr) begin
         check({tag, "/awaddr"}, got_awaddr, a & 32'hFFFF_FFFC);
         check({tag, "/wdata_o"}, got_wdata, exp_data);
         check({tag, "/wstrb"}, 32'(got_wstrb), 32'(exp_strb));
         check({tag, "/aw_cycles"}, 32'(aw_cyc), 32'(awd + 1));
         check({tag, "/w_cycles"}, 32'(w_cyc), 32'(wdd + 1));
         check({tag, "/bready_early"}, 32'(overlap), 32'd0);
      end else begin
         check({tag, "/araddr"}, got_araddr, a & 32'hFFFF_FFFC);
         check({tag, "/ar_cycles"}, 32'(ar_cyc), 32'(ard + 1));
      end
      model_rd = exp_rd;

      // Request is still asserted in the cycle after DONE; it must not restart.
      @(negedge clk);
      check({tag, "/done_pulse"}, 32'(done), 32'd0);
      mem_read = 0; mem_write = 0;
      #1;
      check({tag, "/no_reissue"}, 32'(stall), 32'd0);
      check({tag, "/rd_hold"}, read_data, model_rd);
   endtask

   initial begin
      logic [2:0] lt_tab [5];
      logic [31:0] ra;
      bit          rwr;
      logic [1:0]  rresp_sel;
      lt_tab[0] = LOAD_LB; lt_tab[1] = LOAD_LH; lt_tab[2] = LOAD_LW;
      lt_tab[3] = LOAD_LBU; lt_tab[4] = LOAD_LHU;
      n_vectors = 0; n_miscompares = 0; model_rd = 0;
      cfg_aw_delay = 0; cfg_w_delay = 0; cfg_ar_delay = 0; cfg_r_delay = 0;
      cfg_resp = RESP_OKAY; cfg_rdata = 0;
      rst = 1; mem_read = 0; mem_write = 0; addr = 0; wdata = 0; store_type = 0; load_type = 0;

      repeat (3) @(negedge clk);
      check("reset/awvalid", 32'(awvalid), 32'd0);
      check("reset/wvalid", 32'(wvalid), 32'd0);
      check("reset/arvalid", 32'(arvalid), 32'd0);
      check("reset/bready", 32'(bready), 32'd0);
      check("reset/rready", 32'(rready), 32'd0);
      check("reset/done", 32'(done), 32'd0);
      check("reset/err", 32'(err), 32'd0);
      check("reset/read_data", read_data, 32'd0);
      check("reset/awaddr", awaddr, 32'd0);
      check("reset/araddr", araddr, 32'd0);
      check("reset/wdata_o", wdata_o, 32'd0);
      check("reset/wstrb", 32'(wstrb), 32'd0);
      check("reset/stall", 32'(stall), 32'd0);
      check("reset/prot", 32'({awprot, arprot}), 32'd0);
      rst = 0;

      run_txn("sb_1003", 1, 32'h1003, 32'h0000_00AB, STORE_SB, LOAD_LB, 0, 0, 0, 0,
              RESP_OKAY, 32'h0);
      run_txn("lh_2002", 0, 32'h2002, 32'h0, STORE_SW, LOAD_LH, 0, 0, 0, 0,
              RESP_OKAY, 32'h80FF_1234);
      run_txn("lhu_2002", 0, 32'h2002, 32'h0, STORE_SW, LOAD_LHU, 0, 0, 0, 0,
              RESP_OKAY, 32'h80FF_1234);
      run_txn("sw_aw_slow", 1, 32'h5000, 32'hDEAD_BEEF, STORE_SW, LOAD_LW, 4, 0, 0, 0,
              RESP_OKAY, 32'h0);
      run_txn("sh_w_slow", 1, 32'h5006, 32'h0000_C3A5, STORE_SH, LOAD_LW, 0, 3, 0, 0,
              RESP_DECERR, 32'h0);
      run_txn("lw_misaligned", 0, 32'h3002, 32'h0, STORE_SW, LOAD_LW, 0, 0, 0, 0,
              RESP_OKAY, 32'h1234_5678);
      run_txn("lw_slverr", 0, 32'h3000, 32'h0, STORE_SW, LOAD_LW, 1, 0, 1, 2,
              RESP_SLVERR, 32'hCAFE_F00D);
      run_txn("lb_neg", 0, 32'h3001, 32'h0, STORE_SW, LOAD_LB, 0, 0, 0, 0,
              RESP_OKAY, 32'h0000_9000);

      // Reset while waiting for read data.
      cfg_ar_delay = 0; cfg_r_delay = 50; cfg_resp = RESP_OKAY; cfg_rdata = 32'h1111_2222;
      @(negedge clk);
      mem_read = 1; addr = 32'h4000; load_type = LOAD_LW;
      for (int k = 0; k < 20 && !rready; k++) @(negedge clk);
      check("rst_mid/in_rd_data", 32'(rready), 32'd1);
      rst = 1; mem_read = 0;
      #1;
      check("rst_mid/arvalid", 32'(arvalid), 32'd0);
      check("rst_mid/rready", 32'(rready), 32'd0);
      check("rst_mid/stall", 32'(stall), 32'd0);
      check("rst_mid/done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 0; model_rd = 0;
      run_txn("lw_after_rst", 0, 32'h4004, 32'h0, STORE_SW, LOAD_LW, 0, 0, 0, 0,
              RESP_OKAY, 32'h7654_3210);

      for (int i = 0; i < 40; i++) begin
         rwr = 1'($urandom_range(0, 1));
         ra = $urandom;
         if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
         rresp_sel = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : RESP_OKAY;
         run_txn($sformatf("rand%0d", i), rwr, ra, $urandom, 2'($urandom_range(0, 2)),
                 lt_tab[$urandom_range(0, 4)], $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 2), rresp_sel, $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
